// File: rtl/pmem_line_responder.sv
// Line-granular physical memory behind the cache pmem port: fixed-latency read/write service
// with a one-cycle pmem_resp pulse, saturating op counters and a sticky protocol-error flag.
module pmem_line_responder #(
  parameter int unsigned LINE_BITS   = 128,
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned OFFSET_BITS = 4,
  parameter int unsigned INDEX_BITS  = 8,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [ADDR_BITS-1:0] pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 busy,
  output logic                 proto_err,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam int unsigned Lines   = 2 ** INDEX_BITS;
  localparam logic [7:0]  CntInit = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic                    op_wr_q;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [LINE_BITS-1:0]    wdata_q;
  logic [LINE_BITS-1:0]    mem [Lines];
  logic [Lines-1:0]        valid_q;

  logic [INDEX_BITS-1:0]   idx_in;
  logic [INDEX_BITS-1:0]   rd_idx;
  logic [LINE_BITS-1:0]    rd_line;
  logic                    strobe_ok;
  logic                    commit;
  logic                    unused_addr;

  assign idx_in      = pmem_address[OFFSET_BITS +: INDEX_BITS];
  // Offset and alias bits above the index are deliberately ignored.
  assign unused_addr = ^pmem_address;

  always_comb begin
    rd_idx    = (state_q == StIdle) ? idx_in : idx_q;
    rd_line   = valid_q[rd_idx] ? mem[rd_idx] : '0;
    strobe_ok = op_wr_q ? (pmem_write && !pmem_read) : (pmem_read && !pmem_write);
    commit    = !rst && (state_q == StResp) && op_wr_q;
  end

  // Storage array is not reset; only the per-line valid bits are.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      valid_q    <= '0;
      pmem_rdata <= '0;
      pmem_resp  <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      pmem_resp <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pmem_read ^ pmem_write) begin
            op_wr_q <= pmem_write;
            idx_q   <= idx_in;
            wdata_q <= pmem_wdata;
            cnt_q   <= CntInit;
            if (LATENCY <= 1) begin
              state_q   <= StResp;
              pmem_resp <= 1'b1;
              if (pmem_read) pmem_rdata <= rd_line;
            end else begin
              state_q <= StWait;
              busy    <= 1'b1;
            end
          end else if (pmem_read && pmem_write) begin
            proto_err <= 1'b1;
          end
        end
        StWait: begin
          if (!strobe_ok) begin
            proto_err <= 1'b1;
            state_q   <= StIdle;
            busy      <= 1'b0;
          end else if (cnt_q <= 8'd1) begin
            // Last wait cycle: response lands exactly LATENCY cycles after the sample.
            state_q   <= StResp;
            busy      <= 1'b0;
            pmem_resp <= 1'b1;
            if (!op_wr_q) pmem_rdata <= rd_line;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (op_wr_q) begin
            valid_q[idx_q] <= 1'b1;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
          end else begin
            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
